// File: rtl/riscv_pkg.sv
// Shared constants and helpers for the fetch front end.
//   XLEN      : address / instruction width
//   RESET_PC  : PC loaded on reset
//   NOP_INSTR : value shown on an invalid slot (addi x0,x0,0)
//   PC_STEP   : byte increment between consecutive instruction words
package riscv_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_1000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    TAKE_NONE = 2'd0,
    TAKE_ONE  = 2'd1,
    TAKE_TWO  = 2'd2
  } take_t;

  // Decode may request 3 but the front end only has two slots.
  function automatic take_t sat_take(input logic [1:0] req);
    return (req == 2'd3) ? TAKE_TWO : take_t'(req);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction buffer: one write port, two combinational read ports
// at head and head+1, pops 0..2 entries per cycle, synchronous flush.
//   clk, rst_n      : clock, synchronous active-low reset
//   flush           : empty the queue this edge (overrides push/pop)
//   push            : write {push_instr, push_pc} at tail
//   pop_cnt         : entries removed from head (caller limits to count)
//   count           : occupancy 0..DEPTH
//   valid           : bit0 head valid, bit1 head+1 valid
//   head0_*/head1_* : raw entry contents at head and head+1
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 32,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_instr,
  input  logic [W-1:0]  push_pc,
  input  logic [1:0]    pop_cnt,
  output logic [CW-1:0] count,
  output logic [1:0]    valid,
  output logic [W-1:0]  head0_instr,
  output logic [W-1:0]  head0_pc,
  output logic [W-1:0]  head1_instr,
  output logic [W-1:0]  head1_pc
);

  logic [W-1:0]  mem_instr [DEPTH];
  logic [W-1:0]  mem_pc    [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] head_p1;

  // Storage carries no reset; the top masks invalid slots.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_instr[tail] <= push_instr;
      mem_pc[tail]    <= push_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      // PW-bit truncation makes a pop of 2 wrap correctly even for DEPTH=2.
      head  <= head + PW'(pop_cnt);
      tail  <= tail + PW'(push);
      count <= count - CW'(pop_cnt) + CW'(push);
    end
  end

  assign head_p1     = head + PW'(1);
  assign valid[0]    = (count != '0);
  assign valid[1]    = (count > CW'(1));
  assign head0_instr = mem_instr[head];
  assign head0_pc    = mem_pc[head];
  assign head1_instr = mem_instr[head_p1];
  assign head1_pc    = mem_pc[head_p1];

endmodule

// File: rtl/fetch_sequencer.sv
// Front-end fetch controller: owns the PC, addresses the combinational
// instruction ROM, queues fetched words and presents up to two in-order
// instructions to decode. A redirect flushes the queue and reloads the PC.
//   clk, rst_n        : clock, synchronous active-low reset
//   imem_addr         : ROM byte address (= PC)
//   imem_rdata        : ROM word for imem_addr, same cycle
//   redirect_valid/pc : taken branch/jump from execute
//   slot_valid        : bit0 slot0 valid, bit1 slot1 valid
//   slot0_*/slot1_*   : oldest / second-oldest queued instruction and PC
//   dec_take          : instructions decode consumes this cycle (3 acts as 2)
//   fq_count          : queue occupancy
module fetch_sequencer
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = riscv_pkg::RESET_PC,
  parameter int          FQ_DEPTH = 4,
  parameter int          XLEN     = riscv_pkg::XLEN,
  localparam int         CW       = $clog2(FQ_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [1:0]      slot_valid,
  output logic [XLEN-1:0] slot0_instr,
  output logic [XLEN-1:0] slot0_pc,
  output logic [XLEN-1:0] slot1_instr,
  output logic [XLEN-1:0] slot1_pc,
  input  logic [1:0]      dec_take,
  output logic [CW-1:0]   fq_count
);

  logic [XLEN-1:0] pc;
  take_t           take_req;
  logic [1:0]      take_eff;
  logic [1:0]      pop_cnt;
  logic            fetch_en;
  logic [1:0]      q_valid;
  logic [XLEN-1:0] h0_instr, h0_pc, h1_instr, h1_pc;

  // Never pop more than is queued.
  assign take_req = sat_take(dec_take);
  assign take_eff = (CW'(take_req) > fq_count) ? fq_count[1:0] : 2'(take_req);
  assign pop_cnt  = redirect_valid ? 2'd0 : take_eff;

  // Room is judged after this cycle's pops, so a full queue still fetches
  // while decode drains it.
  assign fetch_en = !redirect_valid && ((fq_count - CW'(take_eff)) < CW'(FQ_DEPTH));

  always_ff @(posedge clk) begin
    if (!rst_n)
      pc <= XLEN'(RESET_PC);
    else if (redirect_valid)
      pc <= {redirect_pc[XLEN-1:2], 2'b00};
    else if (fetch_en)
      pc <= pc + XLEN'(PC_STEP);
  end

  assign imem_addr = pc;

  fetch_queue #(
    .DEPTH (FQ_DEPTH),
    .W     (XLEN)
  ) u_fq (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (redirect_valid),
    .push        (fetch_en),
    .push_instr  (imem_rdata),
    .push_pc     (pc),
    .pop_cnt     (pop_cnt),
    .count       (fq_count),
    .valid       (q_valid),
    .head0_instr (h0_instr),
    .head0_pc    (h0_pc),
    .head1_instr (h1_instr),
    .head1_pc    (h1_pc)
  );

  // Invalid slots show NOP/0 so unwritten storage never leaks X.
  assign slot_valid  = q_valid;
  assign slot0_instr = q_valid[0] ? h0_instr : XLEN'(NOP_INSTR);
  assign slot0_pc    = q_valid[0] ? h0_pc    : '0;
  assign slot1_instr = q_valid[1] ? h1_instr : XLEN'(NOP_INSTR);
  assign slot1_pc    = q_valid[1] ? h1_pc    : '0;

endmodule
